// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers and a Busy/Done handshake.
// Optional MADD/MSUB accumulate ops are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accStep;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   aOrig;
  logic [CW-1:0]      cnt;
  logic               divR;
  logic               macR;
  logic               subR;
  logic               negQ;
  logic               negR;
  logic               dz;

  logic             isMac;
  logic             isMul;
  logic             isDiv;
  logic             isMt;
  logic             opSigned;
  logic             aNeg;
  logic             bNeg;
  logic             issue;
  logic [WIDTH-1:0] aAbs;
  logic [WIDTH-1:0] bAbs;

`ifdef MULDIV_MADD_EN
  assign isMac = Op[2] & Op[1];
`else
  assign isMac = 1'b0;
`endif

  assign isMul    = (Op[2:1] == 2'b00) | isMac;
  assign isDiv    = (Op[2:1] == 2'b01);
  assign isMt     = (Op[2:1] == 2'b10);
  assign opSigned = isMac | ~Op[0];
  assign aNeg     = opSigned & OperandA[WIDTH-1];
  assign bNeg     = opSigned & OperandB[WIDTH-1];
  assign aAbs     = aNeg ? -OperandA : OperandA;
  assign bAbs     = bNeg ? -OperandB : OperandB;
  assign issue    = Start & ~Flush;

  // Multiply: low half holds the multiplier, shifted out LSB first.
  // Divide: high half is the partial remainder, low half dividend/quotient.
  logic [WIDTH:0] mulSum;
  logic [WIDTH:0] divTrial;
  logic [WIDTH:0] divDiff;
  logic           divGe;

  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, opnd} : '0);
    divTrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divDiff  = divTrial - {1'b0, opnd};
    divGe    = ~divDiff[WIDTH];
    if (divR) begin
      accStep = {divGe ? divDiff[WIDTH-1:0] : divTrial[WIDTH-1:0],
                 acc[WIDTH-2:0], divGe};
    end else begin
      accStep = {mulSum, acc[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hiRes;
  logic [WIDTH-1:0]   loRes;

  always_comb begin
    prod  = negQ ? -acc : acc;
    quo   = acc[WIDTH-1:0];
    rem   = acc[2*WIDTH-1:WIDTH];
    hiRes = HI;
    loRes = LO;
    if (divR) begin
      if (dz) begin
        hiRes = aOrig;
        loRes = '1;
      end else begin
        loRes = negQ ? -quo : quo;
        hiRes = negR ? -rem : rem;
      end
    end else if (macR) begin
      {hiRes, loRes} = subR ? ({HI, LO} - prod) : ({HI, LO} + prod);
    end else begin
      {hiRes, loRes} = prod;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (issue && (isMul || isDiv)) begin
          stateNext = ITER;
        end
      end
      ITER: begin
        if (Flush) begin
          stateNext = IDLE;
        end else if (cnt == CW'(WIDTH - 1)) begin
          stateNext = FIX;
        end
      end
      FIX: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc       <= '0;
      opnd      <= '0;
      aOrig     <= '0;
      cnt       <= '0;
      divR      <= 1'b0;
      macR      <= 1'b0;
      subR      <= 1'b0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      dz        <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue && isMt) begin
            if (Op[0]) begin
              LO <= OperandA;
            end else begin
              HI <= OperandA;
            end
            Done <= 1'b1;
          end else if (issue && (isMul || isDiv)) begin
            acc   <= {{WIDTH{1'b0}}, isDiv ? aAbs : bAbs};
            opnd  <= isDiv ? bAbs : aAbs;
            aOrig <= OperandA;
            cnt   <= '0;
            divR  <= isDiv;
            macR  <= isMac;
            subR  <= Op[0];
            negQ  <= aNeg ^ bNeg;
            negR  <= aNeg;
            dz    <= isDiv & (OperandB == '0);
          end
        end
        ITER: begin
          if (!Flush) begin
            acc <= accStep;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!Flush) begin
            HI        <= hiRes;
            LO        <= loRes;
            Done      <= 1'b1;
            DivByZero <= divR & dz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences
// and randomized ops against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] OperandA;
  logic [W-1:0] OperandB;
  logic         Flush;
  logic         Busy;
  logic         Done;
  logic         DivByZero;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Op(Op),
    .OperandA(OperandA),
    .OperandB(OperandB),
    .Flush(Flush),
    .Busy(Busy),
    .Done(Done),
    .DivByZero(DivByZero),
    .HI(HI),
    .LO(LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int errors = 0;
  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural result.
  function automatic void model(input logic [2:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                inout logic [W-1:0] hi, inout logic [W-1:0] lo,
                                output logic dz);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0] hl;
    dz = 1'b0;
    hl = {hi, lo};
    case (op)
      3'd0: hl = sa * sb;
      3'd1: hl = ua * ub;
      3'd2, 3'd3: begin
        if (b == '0) begin
          dz = 1'b1;
          hl = {a, 32'hFFFFFFFF};
        end else if (op == 3'd2) begin
          hl = {32'(sa % sb), 32'(sa / sb)};
        end else begin
          hl = {a % b, a / b};
        end
      end
      3'd4: hl = {a, lo};
      3'd5: hl = {hi, a};
`ifdef MULDIV_MADD_EN
      3'd6: hl = hl + 64'(sa * sb);
      3'd7: hl = hl - 64'(sa * sb);
`endif
      default: ;
    endcase
    {hi, lo} = hl;
  endfunction

  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string nm);
    int n;
    logic busyOk;
    logic dzE;
    int latE;
    model(op, a, b, mHi, mLo, dzE);
    latE = (op == 3'd4 || op == 3'd5) ? 0 : LAT;
    @(negedge Clk);
    Start = 1'b1;
    Op = op;
    OperandA = a;
    OperandB = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    n = 0;
    busyOk = 1'b1;
    while (!Done && n < 200) begin
      if (!Busy) busyOk = 1'b0;
      @(posedge Clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(latE));
    chk({nm, " busy"}, {63'b0, busyOk & ~Busy}, 64'd1);
    chk({nm, " hilo"}, {HI, LO}, {mHi, mLo});
    chk({nm, " dz"}, {63'b0, DivByZero}, {63'b0, dzE});
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n;
    logic seen;
    Reset = 1'b0;
    Start = 1'b0;
    Op = '0;
    OperandA = '0;
    OperandB = '0;
    Flush = 1'b0;

    tbl[0]  = '{3'd4, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{3'd5, 32'h1234, 32'h0, 32'hDEADBEEF, 32'h1234};
    tbl[2]  = '{3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[3]  = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14};
    tbl[4]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[5]  = '{3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF};
    tbl[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    tbl[7]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
    tbl[8]  = '{3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF};
    tbl[9]  = '{3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    tbl[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};

    repeat (2) @(posedge Clk);
    #1;
    chk("reset hilo", {HI, LO}, 64'h0);
    chk("reset flags", {61'b0, Busy, Done, DivByZero}, 64'h0);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      runOp(tbl[i].op, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table", i), {HI, LO}, {tbl[i].hi, tbl[i].lo});
    end

    // Flush mid-ITER with an ignored Start in between.
    runOp(3'd4, 32'h11, 32'h0, "mthi11");
    runOp(3'd5, 32'h11, 32'h0, "mtlo11");
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; OperandA = 32'd6; OperandB = 32'd7;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b1; Op = 3'd4; OperandA = 32'h99;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    chk("ignored start", {62'b0, Busy, Done}, 64'h2);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Flush = 1'b1;
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    chk("flush busy", {63'b0, Busy}, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (Done) seen = 1'b1;
    end
    chk("flush no done", {63'b0, seen}, 64'h0);
    chk("flush hilo", {HI, LO}, {32'h11, 32'h11});

    // Start during Busy on an op that completes.
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; OperandA = 32'd2; OperandB = 32'd3;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b1; Op = 3'd5; OperandA = 32'd5;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    n = 0;
    while (!Done && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("busy start done", {63'b0, Done}, 64'h1);
    chk("busy start hilo", {HI, LO}, {32'h0, 32'h6});
    @(posedge Clk);
    #1;
    chk("done pulse", {63'b0, Done}, 64'h0);
    mHi = 32'h0;
    mLo = 32'h6;

    // MTHI then MTLO on back-to-back cycles.
    @(negedge Clk);
    Start = 1'b1; Op = 3'd4; OperandA = 32'hDEADBEEF;
    @(posedge Clk);
    #1;
    chk("mthi b2b", {62'b0, Busy, Done}, 64'h1);
    @(negedge Clk);
    Op = 3'd5; OperandA = 32'h1234;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    chk("mtlo b2b", {62'b0, Busy, Done}, 64'h1);
    chk("mt b2b hilo", {HI, LO}, {32'hDEADBEEF, 32'h1234});
    mHi = 32'hDEADBEEF;
    mLo = 32'h1234;

    // Flush and Start in the same IDLE cycle drops the op.
    @(negedge Clk);
    Start = 1'b1; Flush = 1'b1; Op = 3'd4; OperandA = 32'h55;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Flush = 1'b0;
    chk("flush+start", {62'b0, Busy, Done}, 64'h0);
    chk("flush+start hilo", {HI, LO}, {mHi, mLo});

    // Asynchronous reset mid-ITER.
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; OperandA = 32'd9; OperandB = 32'd9;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("reset mid busy", {62'b0, Busy, Done}, 64'h0);
    chk("reset mid hilo", {HI, LO}, 64'h0);
    @(negedge Clk);
    Reset = 1'b1;
    mHi = '0;
    mLo = '0;

`ifdef MULDIV_MADD_EN
    runOp(3'd5, 32'd10, 32'd0, "mtlo10");
    runOp(3'd6, 32'd3, 32'd4, "madd");
    chk("madd value", {HI, LO}, {32'h0, 32'd22});
    runOp(3'd7, 32'd5, 32'd5, "msub");
    chk("msub value", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
`else
    runOp(3'd4, 32'hA5, 32'h0, "mthiA5");
    @(negedge Clk);
    Start = 1'b1; Op = 3'd6; OperandA = 32'd3; OperandB = 32'd4;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done || Busy) seen = 1'b1;
      @(posedge Clk);
      #1;
    end
    chk("op110 noop", {63'b0, seen}, 64'h0);
    chk("op110 hilo", {HI, LO}, {32'hA5, 32'h0});
`endif

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic [W-1:0] a;
      logic [W-1:0] b;
`ifdef MULDIV_MADD_EN
      op = 3'($urandom_range(0, 7));
`else
      op = 3'($urandom_range(0, 5));
`endif
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'(($urandom_range(1, 20)));
        default: b = $urandom;
      endcase
      runOp(op, a, b, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
